// File: rtl/sprite_collision_detect.sv
// Per-frame wall-pixel probe around the sprite; latches a collision verdict
// and hit count on the vsync fall, ahead of the motion block's vsync rise.
module sprite_collision_detect #(
    parameter logic [11:0] WALL_RGB   = 12'h000,
    parameter logic [7:0]  HIT_THRESH = 8'd1,
    parameter int          PIX_LAT    = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       vs,
    input  logic       blank,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [7:0] keycode,
    input  logic [9:0] spriteX,
    input  logic [9:0] spriteY,
    input  logic [9:0] spriteS,
    input  logic [3:0] bg_red,
    input  logic [3:0] bg_green,
    input  logic [3:0] bg_blue,
    output logic       collision,
    output logic [7:0] hit_count
);

    localparam logic [1:0] WAIT_VS_HI = 2'd0;
    localparam logic [1:0] SCAN       = 2'd1;
    localparam logic [1:0] LATCH      = 2'd2;

    logic [1:0] state;
    logic       vs_q;
    logic       rise, fall;
    logic [7:0] counter;
    logic [9:0] snap_x, snap_y, snap_s;
    logic [7:0] snap_key;
    logic [9:0] px, py;
    logic       pb;

    generate
        if (PIX_LAT == 0) begin : g_direct
            assign px = DrawX;
            assign py = DrawY;
            assign pb = blank;
        end else begin : g_delay
            logic [PIX_LAT-1:0][9:0] dx_q;
            logic [PIX_LAT-1:0][9:0] dy_q;
            logic [PIX_LAT-1:0]      b_q;

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    dx_q <= '0;
                    dy_q <= '0;
                    b_q  <= '0;
                end else begin
                    dx_q[0] <= DrawX;
                    dy_q[0] <= DrawY;
                    b_q[0]  <= blank;
                    for (int i = 1; i < PIX_LAT; i++) begin
                        dx_q[i] <= dx_q[i-1];
                        dy_q[i] <= dy_q[i-1];
                        b_q[i]  <= b_q[i-1];
                    end
                end
            end

            assign px = dx_q[PIX_LAT-1];
            assign py = dy_q[PIX_LAT-1];
            assign pb = b_q[PIX_LAT-1];
        end
    endgenerate

    assign rise = vs & ~vs_q;
    assign fall = ~vs & vs_q;

    // 12-bit signed keeps X+S+1 and X-S-1 from wrapping for any 10-bit input
    logic signed [11:0] sx, sy, ss, pxs, pys;
    logic signed [11:0] xl, xh, yl, yh;
    logic               in_reg, wall, hit;

    assign sx  = $signed({2'b00, snap_x});
    assign sy  = $signed({2'b00, snap_y});
    assign ss  = $signed({2'b00, snap_s});
    assign pxs = $signed({2'b00, px});
    assign pys = $signed({2'b00, py});

    always_comb begin
        xl = sx - ss;
        xh = sx + ss;
        yl = sy - ss;
        yh = sy + ss;
        unique case (1'b1)
            (snap_key == 8'h04): begin
                xl = sx - ss - 12'sd1;
                xh = xl;
            end
            (snap_key == 8'h07): begin
                xl = sx + ss + 12'sd1;
                xh = xl;
            end
            (snap_key == 8'h1A): begin
                yl = sy - ss - 12'sd1;
                yh = yl;
            end
            (snap_key == 8'h16): begin
                yl = sy + ss + 12'sd1;
                yh = yl;
            end
            default: ;
        endcase
    end

    assign in_reg = (pxs >= xl) && (pxs <= xh) &&
                    (pys >= yl) && (pys <= yh) &&
                    (px < 10'd640) && (py < 10'd480);
    assign wall   = ({bg_red, bg_green, bg_blue} == WALL_RGB);
    assign hit    = pb & in_reg & wall;

    // vs_q resets high so a vsync already high at release is not a rise
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= WAIT_VS_HI;
            vs_q      <= 1'b1;
            counter   <= '0;
            snap_x    <= '0;
            snap_y    <= '0;
            snap_s    <= '0;
            snap_key  <= '0;
            collision <= 1'b0;
            hit_count <= '0;
        end else begin
            vs_q <= vs;
            case (state)
                WAIT_VS_HI: begin
                    if (rise) begin
                        snap_x   <= spriteX;
                        snap_y   <= spriteY;
                        snap_s   <= spriteS;
                        snap_key <= keycode;
                        counter  <= '0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit && counter != 8'hFF)
                        counter <= counter + 8'd1;
                    if (fall)
                        state <= LATCH;
                end
                LATCH: begin
                    hit_count <= counter;
                    collision <= (counter >= HIT_THRESH);
                    state     <= WAIT_VS_HI;
                end
                default: state <= WAIT_VS_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_collision_detect.sv
// Randomized and directed bench for sprite_collision_detect against a
// pixel-list reference model of the probe-region rules.
module tb_sprite_collision_detect;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       vs = 1'b0;
    logic       blank = 1'b0;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic [7:0] keycode = '0;
    logic [9:0] spriteX = '0, spriteY = '0, spriteS = '0;
    logic [3:0] bg_red = 4'hF, bg_green = 4'hF, bg_blue = 4'hF;
    logic       collision, collision2;
    logic [7:0] hit_count, hit_count2;

    sprite_collision_detect #(.PIX_LAT(1)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .vs(vs), .blank(blank),
        .DrawX(DrawX), .DrawY(DrawY), .keycode(keycode),
        .spriteX(spriteX), .spriteY(spriteY), .spriteS(spriteS),
        .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .collision(collision), .hit_count(hit_count)
    );

    sprite_collision_detect #(.PIX_LAT(2)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .vs(vs), .blank(blank),
        .DrawX(DrawX), .DrawY(DrawY), .keycode(keycode),
        .spriteX(spriteX), .spriteY(spriteY), .spriteS(spriteS),
        .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .collision(collision2), .hit_count(hit_count2)
    );

    always #20 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    int lat = 1;
    logic [11:0] hist [4];
    int mcount, m_kc, m_x, m_y, m_s;

    function automatic bit in_region(int kc, int sx, int sy, int ss, int x, int y);
        int xl, xh, yl, yh;
        xl = sx - ss; xh = sx + ss;
        yl = sy - ss; yh = sy + ss;
        if (kc == 'h04) begin xl = sx - ss - 1; xh = xl; end
        else if (kc == 'h07) begin xl = sx + ss + 1; xh = xl; end
        else if (kc == 'h1A) begin yl = sy - ss - 1; yh = yl; end
        else if (kc == 'h16) begin yl = sy + ss + 1; yh = yl; end
        return (x >= xl) && (x <= xh) && (y >= yl) && (y <= yh) &&
               (x >= 0) && (y >= 0) && (x < 640) && (y < 480);
    endfunction

    function automatic logic [11:0] colour(int scene, int x, int y);
        case (scene)
            0: return (x == 351 && y >= 210 && y <= 270) ? 12'h000 : 12'hFFF;
            1: return 12'h000;
            3: return (x == 351 && y == 240) ? 12'h000 : 12'hFFF;
            default: return ($urandom_range(0, 3) == 0) ? 12'h000 : 12'h00F;
        endcase
    endfunction

    task automatic pix(input logic b, input int x, input int y, input logic [11:0] col);
        @(negedge Clk);
        blank = b;
        DrawX = x[9:0];
        DrawY = y[9:0];
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = col;
        {bg_red, bg_green, bg_blue} = hist[lat];
        if (b && col == 12'h000 && in_region(m_kc, m_x, m_y, m_s, x, y))
            mcount++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(1'b0, 0, 0, 12'hFFF);
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1, input int scene);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                pix(1'b1, x, y, colour(scene, x, y));
    endtask

    task automatic frame_begin();
        vs = 1'b0;
        idle(2);
        vs = 1'b1;
        m_kc = int'(keycode);
        m_x = int'(spriteX);
        m_y = int'(spriteY);
        m_s = int'(spriteS);
        mcount = 0;
        idle(2);
    endtask

    task automatic frame_end();
        idle(lat + 2);
        vs = 1'b0;
        idle(3);
    endtask

    function automatic int sat(int c);
        return (c > 255) ? 255 : c;
    endfunction

    task automatic set_scene(input int kc);
        spriteX = 10'd320; spriteY = 10'd240; spriteS = 10'd30;
        keycode = kc[7:0];
    endtask

    task automatic test_reset();
        idle(3);
        checks++;
        if (hit_count !== 8'd0 || collision !== 1'b0) begin
            failures++;
            $display("FAIL reset_out got=%0d/%0b exp=0/0", hit_count, collision);
        end
        checks++;
        if (hit_count2 !== 8'd0 || collision2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_out2 got=%0d/%0b exp=0/0", hit_count2, collision2);
        end
        Reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_wall_right();
        set_scene('h07);
        frame_begin();
        scan(340, 360, 200, 280, 0);
        frame_end();
        checks++;
        if (hit_count !== 8'(sat(mcount)) || mcount != 61) begin
            failures++;
            $display("FAIL right_hits got=%0d exp=%0d (model %0d)", hit_count, 61, mcount);
        end
        checks++;
        if (collision !== 1'b1) begin
            failures++;
            $display("FAIL right_coll got=%0b exp=1", collision);
        end
    endtask

    task automatic test_wall_left();
        set_scene('h04);
        frame_begin();
        scan(340, 360, 200, 280, 0);
        frame_end();
        checks++;
        if (hit_count !== 8'(sat(mcount)) || collision !== 1'b0) begin
            failures++;
            $display("FAIL left got=%0d/%0b exp=%0d/0", hit_count, collision, mcount);
        end
    endtask

    task automatic test_key_snapshot();
        set_scene('h04);
        frame_begin();
        scan(340, 360, 200, 240, 0);
        keycode = 8'h07;
        scan(340, 360, 241, 280, 0);
        frame_end();
        checks++;
        if (hit_count !== 8'(sat(mcount)) || hit_count !== 8'd0) begin
            failures++;
            $display("FAIL snap_hits got=%0d exp=%0d", hit_count, mcount);
        end
        frame_begin();
        scan(340, 360, 200, 280, 0);
        frame_end();
        checks++;
        if (hit_count !== 8'(sat(mcount))) begin
            failures++;
            $display("FAIL snap_next got=%0d exp=%0d", hit_count, mcount);
        end
    endtask

    task automatic test_reset_mid_scan();
        set_scene('h07);
        frame_begin();
        scan(351, 351, 210, 230, 0);
        Reset_n = 1'b0;
        idle(2);
        checks++;
        if (hit_count !== 8'd0 || collision !== 1'b0) begin
            failures++;
            $display("FAIL midreset_out got=%0d/%0b exp=0/0", hit_count, collision);
        end
        Reset_n = 1'b1;
        scan(351, 351, 231, 270, 0);
        frame_end();
        checks++;
        if (hit_count !== 8'd0 || collision !== 1'b0) begin
            failures++;
            $display("FAIL midreset_nolatch got=%0d/%0b exp=0/0", hit_count, collision);
        end
        frame_begin();
        scan(340, 360, 200, 280, 0);
        frame_end();
        checks++;
        if (hit_count !== 8'(sat(mcount)) || collision !== 1'b1) begin
            failures++;
            $display("FAIL midreset_recover got=%0d/%0b exp=%0d/1", hit_count, collision, mcount);
        end
    endtask

    task automatic test_edges();
        spriteX = 10'd10; spriteY = 10'd20; spriteS = 10'd30;
        keycode = 8'h04;
        frame_begin();
        scan(0, 20, 0, 40, 1);
        frame_end();
        checks++;
        if (hit_count !== 8'(sat(mcount)) || hit_count !== 8'd0) begin
            failures++;
            $display("FAIL neg_col got=%0d exp=0", hit_count);
        end
        set_scene('h00);
        frame_begin();
        scan(290, 350, 230, 250, 1);
        frame_end();
        checks++;
        if (hit_count !== 8'(sat(mcount)) || hit_count !== 8'd255) begin
            failures++;
            $display("FAIL saturate got=%0d exp=255 (model %0d)", hit_count, mcount);
        end
        checks++;
        if (collision !== 1'b1) begin
            failures++;
            $display("FAIL saturate_coll got=%0b exp=1", collision);
        end
    endtask

    task automatic test_latency();
        lat = 2;
        set_scene('h07);
        frame_begin();
        scan(340, 360, 240, 240, 3);
        frame_end();
        checks++;
        if (hit_count2 !== 8'd1 || collision2 !== 1'b1 || mcount != 1) begin
            failures++;
            $display("FAIL lat2_aligned got=%0d/%0b exp=1/1", hit_count2, collision2);
        end
        lat = 1;
        frame_begin();
        scan(340, 360, 240, 240, 3);
        frame_end();
        checks++;
        if (hit_count2 !== 8'd0 || collision2 !== 1'b0) begin
            failures++;
            $display("FAIL lat2_early got=%0d/%0b exp=0/0", hit_count2, collision2);
        end
    endtask

    task automatic test_back_to_back();
        int keys [6] = '{'h04, 'h07, 'h1A, 'h16, 'h00, 'h55};
        int x0, x1, y0, y1, e;
        lat = 1;
        for (int f = 0; f < 8; f++) begin
            spriteX = 10'($urandom_range(0, 639));
            spriteY = 10'($urandom_range(0, 479));
            spriteS = 10'($urandom_range(0, 20));
            keycode = 8'(keys[$urandom_range(0, 5)]);
            x0 = int'(spriteX) - int'(spriteS) - 3;
            x1 = int'(spriteX) + int'(spriteS) + 3;
            y0 = int'(spriteY) - int'(spriteS) - 3;
            y1 = int'(spriteY) + int'(spriteS) + 3;
            if (x0 < 0) x0 = 0;
            if (y0 < 0) y0 = 0;
            if (x1 > 639) x1 = 639;
            if (y1 > 479) y1 = 479;
            frame_begin();
            spriteX = 10'($urandom_range(0, 639));
            keycode = 8'(keys[$urandom_range(0, 5)]);
            scan(x0, x1, y0, y1, 2);
            frame_end();
            e = sat(mcount);
            checks++;
            if (hit_count !== 8'(e) || collision !== (e >= 1)) begin
                failures++;
                $display("FAIL rand_frame%0d got=%0d/%0b exp=%0d/%0b",
                         f, hit_count, collision, e, (e >= 1));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) hist[i] = 12'hFFF;
        m_kc = 0; m_x = 0; m_y = 0; m_s = 0; mcount = 0;
        test_reset();
        test_wall_right();
        test_wall_left();
        test_key_snapshot();
        test_reset_mid_scan();
        test_edges();
        test_latency();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
